uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Downstream consumer of the UART slave port of the memory bus (the word at word address 'h100).
//   Each bus write presents one byte on uart_data with a one-cycle uart_write strobe.
//   The block queues these bytes in a FIFO and serialises them onto tx as 8N1 frames, LSB first.
//   This decouples CPU store rate from line rate.
// PARAMETERS
//   CLK_DIV     16   clock cycles per serial bit; legal range >= 2
//   FIFO_DEPTH  16   FIFO entries; must be a power of two, >= 2
// PORTS
//   clk         in   1                    system clock, all state on posedge
//   rst         in   1                    asynchronous, active-high reset
//   uart_write  in   1                    push strobe from bus slave port 2 (we_2)
//   uart_data   in   8                    byte to push (write_data[7:0])
//   tx          out  1                    serial line, idle high
//   busy        out  1                    1 while a frame is on the line or the FIFO is non-empty
//   fifo_full   out  1                    FIFO holds FIFO_DEPTH entries
//   fifo_empty  out  1                    FIFO holds 0 entries
//   fifo_level  out  $clog2(FIFO_DEPTH)+1 current entry count
//   overflow    out  1                    sticky: a push was dropped
// BEHAVIOUR
//   Reset values
//   - tx=1, busy=0, fifo_full=0, fifo_empty=1, fifo_level=0, overflow=0.
//   - FSM=IDLE; read/write pointers=0; baud counter=0.
//   Reset mid-frame
//   - Asserting rst aborts the frame and drives tx high immediately (async).
//   - Queued bytes are discarded.
//   FIFO
//   - Circular buffer; pointers carry one extra wrap bit.
//   - full/empty are decoded from the pointers; fifo_level = wptr - rptr, modulo 2^(log2 DEPTH + 1).
//   - A push is accepted when uart_write && (!fifo_full || pop_this_cycle).
//   - A push while full with no pop is dropped and sets overflow. Only rst clears overflow.
//   - Push and pop in the same cycle: fifo_level is unchanged; both pointers advance.
//   - Push to an empty FIFO is not bypassed. The byte becomes poppable on the next cycle.
//   FSM states: IDLE, START, DATA, STOP (plus PARITY when the macro is defined).
//   - IDLE: tx=1. If !fifo_empty: pop into an 8-bit shift register, load baud counter=CLK_DIV-1, go to START.
//   - START: tx=0 for CLK_DIV cycles. Then go to DATA with bit index=0.
//   - DATA: tx=shift[0] for CLK_DIV cycles per bit, then shift right.
//     After bit index 7 go to STOP (or PARITY).
//   - STOP: tx=1 for CLK_DIV cycles. At the last stop cycle:
//     - if !fifo_empty: pop and go directly to START (no idle gap between frames);
//     - else go to IDLE.
//   Baud counter
//   - Counts down from CLK_DIV-1 to 0; the state or bit advances on the cycle the counter is 0.
//   - Counter width is $clog2(CLK_DIV).
//   Timing
//   - tx output is registered (no glitches).
//   - Latency: uart_write sampled at edge k into an empty FIFO with FSM in IDLE ->
//     pop at edge k+1 -> tx low from edge k+1.
//   - Frame length: 10*CLK_DIV cycles, or 11*CLK_DIV cycles with parity.
//   - busy = (state != IDLE) || !fifo_empty.
// CONFIGURATION
//   UART_TX_PARITY_EN defined
//   - Adds state PARITY between DATA and STOP.
//   - tx = XOR of the 8 data bits (even parity) for CLK_DIV cycles.
//   - Frame becomes 8E1.
//   UART_TX_PARITY_EN undefined
//   - No PARITY state and no parity logic; frame is 8N1.
// TESTING (CLK_DIV=4, FIFO_DEPTH=4 unless noted)
//   1. Single byte: push 'h55 into an idle block.
//      -> tx low 1 cycle after the push edge for 4 cycles,
//      -> then bits 1,0,1,0,1,0,1,0 each 4 cycles,
//      -> then 4 high cycles; busy falls after 40 cycles.
//   2. Back-to-back: push 'hA5,'h3C on consecutive cycles.
//      -> two frames, the second start bit immediately after the first stop bit;
//      -> fifo_level sequence 1,1,0 at the pop points.
//   3. Overflow: push 6 bytes in 6 consecutive cycles.
//      -> first byte popped at the 2nd edge, so 5 accepted;
//      -> 6th dropped, overflow=1 and stays 1;
//      -> only the 5 accepted bytes appear on tx, in order.
//   4. Full with simultaneous pop: fill the FIFO, then push on the exact cycle the FSM pops at STOP end.
//      -> push accepted, overflow stays 0, fifo_level stays 4.
//   5. Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued.
//      -> tx=1 immediately, fifo_empty=1, level=0, busy=0;
//      -> after release a new push 'h01 transmits correctly.
//   6. With UART_TX_PARITY_EN: push 'h07.
//      -> parity bit=1 between bit 7 and stop; frame length 44 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serial transmitter (LSB first, idle high).
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit (8E1 frames).
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_write,
  input  logic [7:0]                    uart_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BaudMax = CW'(CLK_DIV - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd4;
`endif

  // FIFO storage; pointers carry an extra wrap bit to tell full from empty.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          push, pop;
  logic [7:0]    head;

  // Transmitter state.
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign head       = mem[rptr_q[AW-1:0]];
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign fifo_level = wptr_q - rptr_q;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = uart_write && (!fifo_full || pop);
  assign busy       = (state_q != StIdle) || !fifo_empty;

  // FIFO data write; storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= uart_data;
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (uart_write && !push) overflow <= 1'b1;
    end
  end

  // Frame sequencer next-state; each state holds for CLK_DIV cycles via the baud counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = BaudMax;
          state_d = StStart;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          cnt_d   = BaudMax;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d   = BaudMax;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (cnt_q == '0) begin
          cnt_d   = BaudMax;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == '0) begin
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            cnt_d   = BaudMax;
            state_d = StStart;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level derived from the next state so tx can be registered without added latency.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Transmitter registers; reset forces the line idle high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with CLK_DIV=4, FIFO_DEPTH=4.
// Honours UART_TX_PARITY_EN to expect 8E1 frames.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * CLK_DIV;
`else
  localparam int FL = 10 * CLK_DIV;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_write;
  logic [7:0] uart_data;
  logic       tx, busy, fifo_full, fifo_empty, overflow;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  logic [7:0] bytes [6];

  uart_tx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_write (uart_write),
    .uart_data  (uart_data),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; samples and drives happen 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at cycle i of a frame carrying b (cycle 0 = first start-bit cycle).
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i < CLK_DIV) return 1'b0;
    if (i < 9 * CLK_DIV) return b[(i - CLK_DIV) / CLK_DIV];
`ifdef UART_TX_PARITY_EN
    if (i < 10 * CLK_DIV) return ^b;
`endif
    return 1'b1;
  endfunction

  // Check frame cycles first..last-1; entry is just after the edge of cycle 'first'.
  task automatic frame(input logic [7:0] b, input int first, input int last);
    for (int i = first; i < last; i++) begin
      check($sformatf("tx[%02h]#%0d", b, i), {31'd0, tx}, {31'd0, exp_bit(b, i)});
      check($sformatf("busy[%02h]#%0d", b, i), {31'd0, busy}, 32'd1);
      tick();
    end
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, ".tx"},       {31'd0, tx},         32'd1);
    check({tag, ".busy"},     {31'd0, busy},       32'd0);
    check({tag, ".empty"},    {31'd0, fifo_empty}, 32'd1);
    check({tag, ".full"},     {31'd0, fifo_full},  32'd0);
    check({tag, ".level"},    {29'd0, fifo_level}, 32'd0);
    check({tag, ".overflow"}, {31'd0, overflow},   32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    bytes[0] = 8'h11; bytes[1] = 8'hF0; bytes[2] = 8'h33;
    bytes[3] = 8'h44; bytes[4] = 8'h5A; bytes[5] = 8'h66;
    rst = 1'b1;
    uart_write = 1'b0;
    uart_data = 8'h00;
    #12;
    check("rst.tx",       {31'd0, tx},         32'd1);
    check("rst.busy",     {31'd0, busy},       32'd0);
    check("rst.empty",    {31'd0, fifo_empty}, 32'd1);
    check("rst.full",     {31'd0, fifo_full},  32'd0);
    check("rst.level",    {29'd0, fifo_level}, 32'd0);
    check("rst.overflow", {31'd0, overflow},   32'd0);
    rst = 1'b0;
    tick();

    // 1. Single byte 'h55.
    uart_write = 1'b1; uart_data = 8'h55;
    tick();
    uart_write = 1'b0;
    check("t1.level_push", {29'd0, fifo_level}, 32'd1);
    check("t1.busy_push",  {31'd0, busy},       32'd1);
    check("t1.tx_idle",    {31'd0, tx},         32'd1);
    tick();
    check("t1.level_pop",  {29'd0, fifo_level}, 32'd0);
    frame(8'h55, 0, FL);
    check("t1.busy_end",   {31'd0, busy},       32'd0);
    check("t1.tx_end",     {31'd0, tx},         32'd1);

    // 2. Back-to-back 'hA5, 'h3C.
    uart_write = 1'b1; uart_data = 8'hA5;
    tick();
    check("t2.level0", {29'd0, fifo_level}, 32'd1);
    uart_data = 8'h3C;
    tick();
    uart_write = 1'b0;
    check("t2.level1", {29'd0, fifo_level}, 32'd1);
    frame(8'hA5, 0, FL);
    check("t2.level2", {29'd0, fifo_level}, 32'd0);
    frame(8'h3C, 0, FL);
    check("t2.busy_end", {31'd0, busy}, 32'd0);

    // 3. Overflow: six consecutive pushes, the sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      uart_write = 1'b1; uart_data = bytes[i];
      tick();
    end
    uart_write = 1'b0;
    check("t3.level",    {29'd0, fifo_level}, 32'd4);
    check("t3.full",     {31'd0, fifo_full},  32'd1);
    check("t3.overflow", {31'd0, overflow},   32'd1);
    frame(bytes[0], 4, FL);
    for (int i = 1; i < 5; i++) frame(bytes[i], 0, FL);
    check("t3.busy_end",    {31'd0, busy},     32'd0);
    check("t3.overflow_st", {31'd0, overflow}, 32'd1);
    do_reset("t3rst");

    // 4. Full FIFO, push on the exact stop-end pop cycle.
    for (int i = 0; i < 5; i++) begin
      uart_write = 1'b1; uart_data = bytes[i];
      tick();
    end
    uart_write = 1'b0;
    check("t4.full", {31'd0, fifo_full}, 32'd1);
    frame(bytes[0], 3, FL - 1);
    uart_write = 1'b1; uart_data = 8'h77;
    tick();
    uart_write = 1'b0;
    check("t4.level",    {29'd0, fifo_level}, 32'd4);
    check("t4.overflow", {31'd0, overflow},   32'd0);
    check("t4.full2",    {31'd0, fifo_full},  32'd1);
    for (int i = 1; i < 5; i++) frame(bytes[i], 0, FL);
    frame(8'h77, 0, FL);
    check("t4.busy_end", {31'd0, busy}, 32'd0);

    // 5. Reset during data bit 3 of 'hF0 with two bytes queued.
    for (int i = 1; i < 4; i++) begin
      uart_write = 1'b1; uart_data = bytes[i];
      tick();
    end
    uart_write = 1'b0;
    check("t5.level", {29'd0, fifo_level}, 32'd2);
    frame(bytes[1], 1, 4 * CLK_DIV + 1);
    check("t5.tx_bit3", {31'd0, tx}, 32'd0);
    do_reset("t5rst");
    uart_write = 1'b1; uart_data = 8'h01;
    tick();
    uart_write = 1'b0;
    tick();
    frame(8'h01, 0, FL);
    check("t5.busy_end", {31'd0, busy}, 32'd0);

    // 6. 'h07: odd popcount, so the parity bit is 1 when enabled.
    uart_write = 1'b1; uart_data = 8'h07;
    tick();
    uart_write = 1'b0;
    tick();
    frame(8'h07, 0, FL);
    check("t6.busy_end", {31'd0, busy}, 32'd0);
    check("t6.tx_end",   {31'd0, tx},   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
